// File: rtl/operand_skewer.sv
// Feeds a 4x4 systolic array: skews A columns / B rows so lane i lags lane 0 by i beats,
// then flushes zeros until the last skewed column has drained.
module operand_skewer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W*LANES-1:0]   in_a,
    input  logic [DATA_W*LANES-1:0]   in_b,
    output logic [DATA_W*LANES-1:0]   out_a,
    output logic [DATA_W*LANES-1:0]   out_b,
    output logic                      out_valid,
    output logic                      sa_clear,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned BUS_W      = DATA_W * LANES;
    localparam logic [2:0]  FLUSH_LAST = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       len_q;
    logic [3:0]       col_cnt;
    logic [2:0]       flush_cnt;
    logic             accept;
    logic             shift;
    logic             last_col;
    logic [BUS_W-1:0] shin_a;
    logic [BUS_W-1:0] shin_b;
    logic [BUS_W-1:0] tap_a;
    logic [BUS_W-1:0] tap_b;
    logic             in_ready_nxt;
    logic             sa_clear_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    assign accept   = (state == S_FEED) & in_valid;
    assign last_col = (col_cnt == (len_q - 4'd1));
    assign shift    = accept | (state == S_FLUSH);
    assign shin_a   = (state == S_FEED) ? in_a : '0;
    assign shin_b   = (state == S_FEED) ? in_b : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (len == 4'd0) ? S_DONE : S_CLEAR;
            S_CLEAR: state_nxt = S_FEED;
            S_FEED:  if (accept && last_col) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_comb begin
        in_ready_nxt = 1'b0;
        sa_clear_nxt = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        in_ready_nxt = (state_nxt == S_FEED);
        sa_clear_nxt = (state_nxt == S_CLEAR);
        busy_nxt     = (state_nxt != S_IDLE);
        done_nxt     = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= 4'd0;
            col_cnt   <= 4'd0;
            flush_cnt <= 3'd0;
        end else begin
            if ((state == S_IDLE) && start && (len != 4'd0)) len_q <= len;
            if (state == S_CLEAR)  col_cnt <= 4'd0;
            else if (accept)       col_cnt <= col_cnt + 4'd1;
            if (state == S_FLUSH)  flush_cnt <= flush_cnt + 3'd1;
            else                   flush_cnt <= 3'd0;
        end
    end

    assign tap_a[DATA_W-1:0] = shin_a[DATA_W-1:0];
    assign tap_b[DATA_W-1:0] = shin_b[DATA_W-1:0];

    // Lane i delay line is i stages deep; it only advances on shift cycles so stalls keep alignment.
    for (genvar i = 1; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] dla [i];
        logic [DATA_W-1:0] dlb [i];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < i; k++) begin
                    dla[k] <= '0;
                    dlb[k] <= '0;
                end
            end else if (shift) begin
                dla[0] <= shin_a[i*DATA_W +: DATA_W];
                dlb[0] <= shin_b[i*DATA_W +: DATA_W];
                for (int k = 1; k < i; k++) begin
                    dla[k] <= dla[k-1];
                    dlb[k] <= dlb[k-1];
                end
            end
        end

        assign tap_a[i*DATA_W +: DATA_W] = dla[i-1];
        assign tap_b[i*DATA_W +: DATA_W] = dlb[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_a     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            sa_clear  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= shift;
            if (shift) begin
                out_a <= tap_a;
                out_b <= tap_b;
            end
            in_ready <= in_ready_nxt;
            sa_clear <= sa_clear_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_operand_skewer.sv
// Directed bench for operand_skewer: beat contents, stalls, zero/max length, mid-job reset,
// and a behavioural 4x4 output-stationary array fed end to end.
module tb_operand_skewer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic        out_valid;
    logic        sa_clear;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] col_a [16];
    logic [63:0] col_b [16];
    logic [63:0] cap_a [32];

    operand_skewer #(.DATA_W(16), .LANES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_a(out_a), .out_b(out_b),
        .out_valid(out_valid), .sa_clear(sa_clear), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary array: A flows right along rows, B flows down columns.
    logic [15:0] ap  [4][4];
    logic [15:0] bp  [4][4];
    logic [15:0] ain [4][4];
    logic [15:0] bin [4][4];
    logic [31:0] acc [4][4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ain[i][0] = out_a[i*16 +: 16];
            bin[0][i] = out_b[i*16 +: 16];
            for (int j = 1; j < 4; j++) begin
                ain[i][j] = ap[i][j-1];
                bin[j][i] = bp[j-1][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (sa_clear) begin
                    acc[i][j] <= '0;
                    ap[i][j]  <= '0;
                    bp[i][j]  <= '0;
                end else if (out_valid) begin
                    acc[i][j] <= acc[i][j] + 32'(ain[i][j] * bin[i][j]);
                    ap[i][j]  <= ain[i][j];
                    bp[i][j]  <= bin[i][j];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane i of beat t carries column t-i when it exists, else zero.
    function automatic logic [63:0] exp_beat(input int t, input int n, input bit is_b);
        logic [63:0] v;
        logic [63:0] c;
        int          k;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            k = t - i;
            if (k >= 0 && k < n) begin
                c = is_b ? col_b[k] : col_a[k];
                v[i*16 +: 16] = c[i*16 +: 16];
            end
        end
        return v;
    endfunction

    task automatic set_cols();
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) begin
                col_a[c][i*16 +: 16] = 16'(i*256 + c + 1);
                col_b[c][i*16 +: 16] = 16'(32'h8000 + i*256 + c + 1);
            end
        end
    endtask

    // Runs one job; vpat gives in_valid per FEED cycle (cyclic over plen), plen=0 means always valid.
    task automatic run_job(input int n, input logic [7:0] vpat, input int plen);
        int beats;
        int clears;
        int cyc;
        int fidx;
        int col;
        bit seen_done;
        bit acc_now;
        bit gap;
        beats = 0; clears = 0; cyc = 0; fidx = 0; col = 0; seen_done = 1'b0;
        start = 1'b1;
        len   = 4'(n);
        tick();
        start = 1'b0;
        while (!seen_done && cyc < 100) begin
            if (sa_clear) begin
                clears++;
                check("clear_no_beat", 64'(out_valid), 64'd0);
            end
            if (out_valid) begin
                check($sformatf("len%0d_beat%0d_a", n, beats), out_a, exp_beat(beats, n, 1'b0));
                check($sformatf("len%0d_beat%0d_b", n, beats), out_b, exp_beat(beats, n, 1'b1));
                if (beats < 32) cap_a[beats] = out_a;
                beats++;
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_busy", 64'(busy), 64'd1);
                check("done_on_last_beat", 64'(out_valid), 64'(n != 0));
            end else begin
                acc_now = 1'b0;
                gap     = 1'b0;
                if (in_ready) begin
                    in_valid = (plen == 0) ? 1'b1 : vpat[fidx % plen];
                    fidx++;
                    in_a = col_a[(col < 16) ? col : 15];
                    in_b = col_b[(col < 16) ? col : 15];
                    acc_now = in_valid;
                    gap     = !in_valid;
                end else begin
                    in_valid = 1'b0;
                end
                tick();
                cyc++;
                in_valid = 1'b0;
                if (acc_now) col++;
                if (gap) check("stall_gap", 64'(out_valid), 64'd0);
            end
        end
        check($sformatf("len%0d_done_seen", n), 64'(seen_done), 64'd1);
        check($sformatf("len%0d_beat_count", n), 64'(beats), 64'((n == 0) ? 0 : n + 6));
        check($sformatf("len%0d_clear_count", n), 64'(clears), 64'(n != 0));
    endtask

    initial begin
        bit rst_done;
        rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0; in_a = '0; in_b = '0;
        set_cols();
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_sa_clear", 64'(sa_clear), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_a", out_a, 64'd0);
        check("rst_out_b", out_b, 64'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Basic len=4 job, then a start during DONE must be ignored.
        run_job(4, 8'h00, 0);
        check("basic_lane3_beat2", 64'(cap_a[2][63:48]), 64'h0);
        check("basic_lane3_beat3", 64'(cap_a[3][63:48]), 64'h0301);
        check("basic_lane0_beat0", 64'(cap_a[0][15:0]), 64'h0001);
        start = 1'b1;
        len   = 4'd5;
        tick();
        start = 1'b0;
        check("start_in_done_busy", 64'(busy), 64'd0);
        check("start_in_done_clear", 64'(sa_clear), 64'd0);
        tick();
        check("start_in_done_idle", 64'(busy), 64'd0);

        // Stalls: valid pattern 1,0,0,1,0,1.
        run_job(3, 8'b0010_1001, 6);
        tick();

        // Zero length.
        run_job(0, 8'h00, 0);
        tick();
        check("zero_len_idle", 64'(busy), 64'd0);

        // Maximum length.
        run_job(15, 8'h00, 0);
        check("max_lane0_beat14", 64'(cap_a[14][15:0]), 64'h000F);
        check("max_lane0_beat15", 64'(cap_a[15][15:0]), 64'h0);
        check("max_lane0_beat20", 64'(cap_a[20][15:0]), 64'h0);
        tick();

        // Reset after two of four columns.
        start = 1'b1;
        len   = 4'd4;
        tick();
        start = 1'b0;
        tick();
        check("feed_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a = col_a[0]; in_b = col_b[0];
        tick();
        in_a = col_a[1]; in_b = col_b[1];
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_a", out_a, 64'd0);
        check("midrst_out_b", out_b, 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_sa_clear", 64'(sa_clear), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) rst_done = 1'b1;
        end
        check("midrst_no_done", 64'(rst_done), 64'd0);
        run_job(2, 8'h00, 0);
        tick();

        // End to end: A[i][k] = 4i+k+1, B = identity, so the array must hold A.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                col_a[k][i*16 +: 16] = 16'(i*4 + k + 1);
                col_b[k][i*16 +: 16] = (k == i) ? 16'd1 : 16'd0;
            end
        end
        run_job(4, 8'h00, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("e2e_c%0d%0d", i, j), 64'(acc[i][j]), 64'(i*4 + j + 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
